// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell and a carry flop produce the sum LSB first,
// one bit per clock, with a registered result and a one-cycle done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, ps_q, sum_q;
    logic             c_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, busy_d, done_q, done_d;
    logic             s_s, co_s, last_bit_s;

    full_adder u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (c_q),
        .s  (s_s),
        .co (co_s)
    );

    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
                else       state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_bit_s) state_d = ST_DONE;
                else            state_d = ST_SHIFT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they register in step with it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d != ST_IDLE) busy_d = 1'b1;
        else                    busy_d = 1'b0;
        if (state_d == ST_DONE) done_d = 1'b1;
        else                    done_d = 1'b0;
    end

    // Operand shifting, carry chaining and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= {WIDTH{1'b0}};
            sb_q   <= {WIDTH{1'b0}};
            ps_q   <= {WIDTH{1'b0}};
            sum_q  <= {WIDTH{1'b0}};
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q  <= a;
                        sb_q  <= b;
                        c_q   <= cin;
                        cnt_q <= {CW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    ps_q  <= {s_s, ps_q[WIDTH-1:1]};
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    c_q   <= co_s;
                    cnt_q <= cnt_q + CW'(1);
                    // Final bit goes straight into the result, bypassing ps_q
                    if (last_bit_s) begin
                        sum_q  <= {s_s, ps_q[WIDTH-1:1]};
                        cout_q <= co_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle corner sequences,
// and randomised cross-checks on 4- and 16-bit instances, all through expected-result queues.

module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cin, busy, done, cout;
    logic [7:0]  a, b, sum;
    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  sb8[$];
    logic [4:0]  sb4[$];
    logic [16:0] sb16[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        int         disturb;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle8_timeout", {31'd0, busy}, 32'd0);
    endtask

    // One 8-bit operation; optional start pulse with new operands at cycle 'disturb'
    task automatic run_op(input vec_t v);
        int         pulses = 0;
        int         done_at = -1;
        logic       hold_ok = 1'b1;
        logic [7:0] prev_sum;
        logic       prev_cout;
        logic [8:0] exp;
        wait_idle8();
        prev_sum  = sum;
        prev_cout = cout;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb8.push_back({v.co, v.s});
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == v.disturb) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            if (n == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
            if (done) begin
                pulses++;
                done_at = n;
                check("busy_in_done", {31'd0, busy}, 32'd1);
                if (sb8.size() > 0) begin
                    exp = sb8.pop_front();
                    check("sum8", {24'd0, sum}, {24'd0, exp[7:0]});
                    check("cout8", {31'd0, cout}, {31'd0, exp[8]});
                end else begin
                    check("sb8_underflow", 32'd1, 32'd0);
                end
            end else if (pulses == 0 && (sum !== prev_sum || cout !== prev_cout)) begin
                hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("done_pulses", pulses, 32'd1);
        check("done_latency", done_at, 32'd9);
        check("result_hold", {31'd0, hold_ok}, 32'd1);
    endtask

    task automatic reset_mid_op();
        int pulses = 0;
        wait_idle8();
        a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
        sb8.push_back(9'h097);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        sb8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_reset", pulses, 32'd0);
    endtask

    task automatic continuous_start();
        int pulses = 0;
        int t[3] = '{-1, -1, -1};
        logic [8:0] exp;
        wait_idle8();
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        repeat (3) sb8.push_back(9'h002);
        @(posedge clk);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (done) begin
                if (pulses < 3) t[pulses] = n;
                pulses++;
                if (sb8.size() > 0) begin
                    exp = sb8.pop_front();
                    check("cont_sum", {23'd0, cout, sum}, {23'd0, exp});
                end else begin
                    check("cont_sb_underflow", 32'd1, 32'd0);
                end
            end
            if (n == 29) start = 1'b0;
        end
        check("cont_pulses", pulses, 32'd3);
        check("cont_t0", t[0], 32'd9);
        check("cont_t1", t[1], 32'd19);
        check("cont_t2", t[2], 32'd29);
    endtask

    task automatic rand4(input int count);
        logic [4:0] exp;
        int n;
        for (int k = 0; k < count; k++) begin
            n = 0;
            while (busy4 && n < 20) begin @(negedge clk); n++; end
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            sb4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
            start4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            n = 1;
            while (!done4 && n < 20) begin @(negedge clk); n++; end
            exp = sb4.pop_front();
            check("w4_latency", n, 32'd5);
            check("w4_result", {27'd0, cout4, sum4}, {27'd0, exp});
        end
    endtask

    task automatic rand16(input int count);
        logic [16:0] exp;
        int n;
        for (int k = 0; k < count; k++) begin
            n = 0;
            while (busy16 && n < 40) begin @(negedge clk); n++; end
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            sb16.push_back(17'(a16) + 17'(b16) + 17'(cin16));
            start16 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            n = 1;
            while (!done16 && n < 40) begin @(negedge clk); n++; end
            exp = sb16.pop_front();
            check("w16_latency", n, 32'd17);
            check("w16_result", {15'd0, cout16, sum16}, {15'd0, exp});
        end
    endtask

    initial begin
        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0, disturb: 0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1, disturb: 0};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1, disturb: 0};
        vecs[3] = '{a: 8'h5A, b: 8'h3C, cin: 1'b1, s: 8'h97, co: 1'b0, disturb: 0};
        vecs[4] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, co: 1'b0, disturb: 3};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1, disturb: 0};

        rst_n = 1'b0;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (i == 5) reset_mid_op();
            run_op(vecs[i]);
        end
        continuous_start();
        check("sb8_empty", sb8.size(), 32'd0);

        rand4(20);
        rand16(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the existing 1-bit full_adder cell. One instance of that cell plus a carry flip-flop computes the sum LSB first, one bit per clock. Operands are loaded with a start strobe; the result and carry-out are presented with a one-cycle done pulse. It trades the area of a ripple-carry adder for WIDTH cycles of latency and sits in the datapath wherever an adder result is consumed.

Parameters:
WIDTH, 8, operand and sum width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; sum and cout valid
sum  output  WIDTH  registered result; held until the next completion
cout  output  1  registered carry-out; held until the next completion

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (async, any state including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, partial-sum register, carry FF and bit counter all cleared.
  - Any in-flight operation is discarded with no done pulse.
- Datapath:
  - Shift registers sa, sb; partial-sum register ps; carry FF c; counter cnt of width clog2(WIDTH+1).
  - One full_adder instance with inputs (sa[0], sb[0], c) and outputs (s, co).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: sa<=a, sb<=b, c<=cin, cnt<=0, go SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - ps <= {s, ps[WIDTH-1:1]}.
  - sa, sb shift right by 1 with 0 fill.
  - c <= co; cnt <= cnt+1.
  - When cnt==WIDTH-1 on that edge:
    - sum <= {s, ps[WIDTH-1:1]} and cout <= co. These register loads use the final bit directly.
    - Go DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge 0; bits 0..WIDTH-1 are processed at edges 1..WIDTH; done is high in the cycle following edge WIDTH.
  - Issue interval is WIDTH+2 cycles: start can next be accepted at edge WIDTH+2.
- start while busy=1 (SHIFT or DONE) is ignored and not queued. a, b and cin may change freely after the accept edge without affecting the result.
- done, busy, sum and cout are all registered outputs with no combinational path from inputs.
- sum and cout change only on the completion edge. They hold their previous value during SHIFT and after returning to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). This gives exact unsigned results, and two's-complement wrap for sum.
- start held high continuously: a new operation begins every WIDTH+2 cycles, each using a, b and cin as sampled at its own accept edge.

Test Plan:
- WIDTH=8, after reset release -> sum=0x00, cout=0, done=0, busy=0. Then a=0x00, b=0x00, cin=0, start -> sum=0x00, cout=0, done high exactly at cycle 9 after the accept edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple). Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0. sum must stay at the previous result until the done cycle.
- Start accepted with a=0x12, b=0x34. At cycle 3, pulse start with a=0xFF, b=0xFF and change the a/b inputs. Expected: ignored, sum=0x46, cout=0, exactly one done pulse.
- Assert rst_n=0 at cycle 4 of an operation -> busy, done, sum and cout drop to 0 immediately with no done pulse. After release, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1.
- start held high with constant a=0x01, b=0x01, cin=0 -> done pulses every 10 cycles, each with sum=0x02, cout=0.
- Randomised cross-check against a+b+cin for WIDTH=4 and WIDTH=16.
